// File: rtl/tqvp_bus_initiator.sv
// rtl/tqvp_bus_initiator.sv - TinyQV peripheral bus initiator: one read/write command in flight, one response out
// All outputs are flops; next values are computed from the request, the state and data_ready.
module tqvp_bus_initiator #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic [5:0]  req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic        resp_timeout,
   output logic [5:0]  address,
   output logic [31:0] data_in,
   output logic [1:0]  data_write_n,
   output logic [1:0]  data_read_n,
   input  logic [31:0] data_out,
   input  logic        data_ready
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  size_q, size_d;
   logic        req_ready_q, req_ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_error_q, resp_error_d;
   logic        resp_timeout_q, resp_timeout_d;
   logic [5:0]  address_q, address_d;
   logic [31:0] data_in_q, data_in_d;
   logic [1:0]  data_write_n_q, data_write_n_d;
   logic [1:0]  data_read_n_q, data_read_n_d;
   logic [31:0] rdata_masked;

   always_comb begin
      case (size_q)
         2'b00:   rdata_masked = {24'h0, data_out[7:0]};
         2'b01:   rdata_masked = {16'h0, data_out[15:0]};
         default: rdata_masked = data_out;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      size_d         = size_q;
      req_ready_d    = req_ready_q;
      resp_valid_d   = resp_valid_q;
      resp_rdata_d   = resp_rdata_q;
      resp_error_d   = resp_error_q;
      resp_timeout_d = resp_timeout_q;
      address_d      = address_q;
      data_in_d      = data_in_q;
      data_write_n_d = data_write_n_q;
      data_read_n_d  = data_read_n_q;

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               size_d      = req_size;
               cnt_d       = 8'h0;
               req_ready_d = 1'b0;
               // Illegal size never touches the bus; address keeps its last value.
               if (req_size == 2'b11) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_error_d = 1'b1;
               end else if (req_write) begin
                  state_d        = WRITE;
                  address_d      = req_addr;
                  data_in_d      = req_wdata;
                  data_write_n_d = req_size;
               end else begin
                  state_d       = READ;
                  address_d     = req_addr;
                  data_read_n_d = req_size;
               end
            end
         end
         WRITE: begin
            state_d        = RESP;
            data_in_d      = 32'h0;
            data_write_n_d = 2'b11;
            resp_valid_d   = 1'b1;
            resp_rdata_d   = 32'h0;
         end
         READ: begin
            if (data_ready) begin
               state_d       = RESP;
               data_read_n_d = 2'b11;
               resp_valid_d  = 1'b1;
               resp_rdata_d  = rdata_masked;
            end else if (cnt_q == CNT_LAST) begin
               state_d        = RESP;
               data_read_n_d  = 2'b11;
               resp_valid_d   = 1'b1;
               resp_timeout_d = 1'b1;
               resp_rdata_d   = 32'h0;
            end else begin
               cnt_d = cnt_q + 8'h1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d        = IDLE;
               req_ready_d    = 1'b1;
               resp_valid_d   = 1'b0;
               resp_rdata_d   = 32'h0;
               resp_error_d   = 1'b0;
               resp_timeout_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= 8'h0;
         size_q         <= 2'b00;
         req_ready_q    <= 1'b1;
         resp_valid_q   <= 1'b0;
         resp_rdata_q   <= 32'h0;
         resp_error_q   <= 1'b0;
         resp_timeout_q <= 1'b0;
         address_q      <= 6'h0;
         data_in_q      <= 32'h0;
         data_write_n_q <= 2'b11;
         data_read_n_q  <= 2'b11;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         size_q         <= size_d;
         req_ready_q    <= req_ready_d;
         resp_valid_q   <= resp_valid_d;
         resp_rdata_q   <= resp_rdata_d;
         resp_error_q   <= resp_error_d;
         resp_timeout_q <= resp_timeout_d;
         address_q      <= address_d;
         data_in_q      <= data_in_d;
         data_write_n_q <= data_write_n_d;
         data_read_n_q  <= data_read_n_d;
      end
   end

   assign req_ready    = req_ready_q;
   assign resp_valid   = resp_valid_q;
   assign resp_rdata   = resp_rdata_q;
   assign resp_error   = resp_error_q;
   assign resp_timeout = resp_timeout_q;
   assign address      = address_q;
   assign data_in      = data_in_q;
   assign data_write_n = data_write_n_q;
   assign data_read_n  = data_read_n_q;

endmodule

// File: doc/tqvp_bus_initiator.md
Name: tqvp_bus_initiator

Overview:
Initiator (host) side of the TinyQV peripheral bus. Accepts single read/write commands on a valid/ready request port and drives the peripheral-side address, data, and strobe signals. Waits for the peripheral's data_ready, then returns one response per request. Used for bring-up and test harnesses to drive any tqvp_* peripheral without the CPU.

Parameters:
TIMEOUT_CYCLES, 255, read-wait cycles with data_ready low before aborting; range 1..255; 8-bit counter.

Ports:
clk  input  1  clock
rst  input  1  reset; one clock; reset is synchronous and active-high
req_valid  input  1  command valid
req_ready  output  1  command accepted when valid&ready
req_write  input  1  1=write, 0=read
req_size  input  2  00=8b, 01=16b, 10=32b, 11=illegal
req_addr  input  6  peripheral address
req_wdata  input  32  write data
resp_valid  output  1  response valid
resp_ready  input  1  response consumed when valid&ready
resp_rdata  output  32  read data, zero-extended per size; 0 for writes, errors, and timeouts
resp_error  output  1  illegal size
resp_timeout  output  1  read timed out
address  output  6  to peripheral
data_in  output  32  to peripheral write data
data_write_n  output  2  to peripheral; 11=idle
data_read_n  output  2  to peripheral; 11=idle
data_out  input  32  from peripheral read data
data_ready  input  1  from peripheral

Behaviour:
- States: IDLE, WRITE, READ, RESP. All outputs decode from registered state and latched fields; there are no combinational paths from req_* or data_ready to any output.
- Reset, when rst is high at a clock edge:
  - state goes to IDLE and the wait counter clears;
  - all latched fields clear;
  - req_ready=1 (IDLE); resp_valid, resp_error, resp_timeout = 0; resp_rdata = 0;
  - address=0, data_in=0, data_write_n=data_read_n=11.
  - Reset mid-transaction aborts it with no response and drops the strobe on the next cycle.
- IDLE: req_ready=1.
  - On valid&ready, latch addr/wdata/size/write.
  - size=11 goes to RESP with error=1. No bus strobe is issued.
  - Otherwise, a write goes to WRITE and a read goes to READ; the counter clears.
- WRITE: exactly one cycle.
  - address=latched addr, data_in=latched wdata, data_write_n=latched size.
  - Next state is RESP with rdata=0.
- READ: address=latched addr, data_read_n=latched size, held every cycle.
  - If data_ready=1, capture data_out masked by size: 8b as {24'h0,[7:0]}, 16b as {16'h0,[15:0]}, 32b as full. Go to RESP.
  - Else, if counter==TIMEOUT_CYCLES-1, go to RESP with timeout=1 and rdata=0.
  - Else, counter increments.
- RESP: resp_valid=1 with rdata/error/timeout stable. Bus outputs are idle (strobes=11). req_ready=0.
  - On resp_ready, go to IDLE and clear error/timeout/rdata.
- data_in is driven only in WRITE and is 0 otherwise; address holds its last value outside WRITE/READ.
- Latency, with acceptance at edge N:
  - write: strobe during cycle N+1, resp_valid from N+2;
  - read with data_ready already high: strobe during N+1, resp_valid from N+2;
  - each extra wait cycle adds 1.
- Timeout: data_ready held low gives resp_valid TIMEOUT_CYCLES+1 cycles after acceptance.
- One transaction is in flight at a time. A new request cannot be accepted in the same cycle a response is consumed; acceptance resumes the cycle after (IDLE).
- data_ready is sampled only in READ and ignored in all other states.

Test Plan:
- Reset, then a 32b write to addr 0x00 with data 0xDEADBEEF -> data_write_n=10 for exactly 1 cycle with address=0, data_in=0xDEADBEEF; resp_valid 2 cycles after accept, rdata=0, error=0, timeout=0.
- 8b read of addr 0x04 with data_out=0xAABBCCDD and data_ready tied 1 -> data_read_n=00 for 1 cycle; resp_rdata=0x000000DD. The 16b repeat -> 0x0000CCDD. The 32b repeat -> 0xAABBCCDD.
- 32b read where data_ready rises 3 cycles into READ -> data_read_n=10 held 4 cycles; response carries data_out from the ready cycle; resp_valid at accept+5.
- TIMEOUT_CYCLES=4 with data_ready stuck low -> strobe held 4 cycles; resp_timeout=1, rdata=0, resp_valid at accept+5.
- Request with size=11 -> no strobe ever leaves 11; resp_error=1 at accept+1. With resp_ready held 0 for 5 cycles, the response is held stable and req_ready=0 throughout.
- rst asserted during the 2nd wait cycle of a read -> next cycle data_read_n=11, resp_valid=0, req_ready=1; a subsequent write completes normally.
